// File: rtl/pio_sched_if.sv
// pio_sched_if: control, forced-exec and per-machine signals of the PIO scheduler
// master drives ctrl_wr/ctrl_data, exec_req/exec_sm/exec_instr and sm_step;
// slave (pio_sched) drives en, restart, div_restart, imm, imm_instr,
// exec_busy, exec_done and exec_abort.
interface pio_sched_if #(parameter int NSM = 4);
  logic             ctrl_wr;
  logic [3*NSM-1:0] ctrl_data;
  logic             exec_req;
  logic [1:0]       exec_sm;
  logic [15:0]      exec_instr;
  logic [NSM-1:0]   sm_step;
  logic [NSM-1:0]   en;
  logic [NSM-1:0]   restart;
  logic [NSM-1:0]   div_restart;
  logic [NSM-1:0]   imm;
  logic [15:0]      imm_instr;
  logic             exec_busy;
  logic             exec_done;
  logic             exec_abort;
  modport master (
    output ctrl_wr, ctrl_data, exec_req, exec_sm, exec_instr, sm_step,
    input  en, restart, div_restart, imm, imm_instr, exec_busy, exec_done, exec_abort
  );
  modport slave (
    input  ctrl_wr, ctrl_data, exec_req, exec_sm, exec_instr, sm_step,
    output en, restart, div_restart, imm, imm_instr, exec_busy, exec_done, exec_abort
  );
endinterface

// File: rtl/pio_sched.sv
// pio_sched: state-machine enable/restart control and forced single-instruction execution
// Ports: clk, reset (async, active-low), b (pio_sched_if.slave).
// ctrl_wr loads the enable mask and fires one-cycle restart/div_restart pulses;
// exec_req captures a target and instruction, presents it for one LOAD cycle,
// then waits (forcing the target enabled) until the target steps or is restarted.
module pio_sched #(
  parameter int NSM = 4
) (
  input logic       clk,
  input logic       reset,
  pio_sched_if.slave b
);
  typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;
  state_t         state, state_nx;
  logic [NSM-1:0] en_q, rst_q, div_q, tgt_oh;
  logic [1:0]     tgt;
  logic [15:0]    instr_q;
  logic           done_q, abort_q, accept, abort, step;
  always_comb begin
    tgt_oh   = NSM'(1) << tgt;
    accept   = state == IDLE && b.exec_req && {30'd0, b.exec_sm} < NSM;
    // a restart of the target ends the exec and wins over a same-cycle step
    abort    = state != IDLE && b.ctrl_wr && (b.ctrl_data[2*NSM-1:NSM] & tgt_oh) != '0;
    step     = state == WAIT && (b.sm_step & tgt_oh) != '0;
    state_nx = accept ? LOAD : (abort || step) ? IDLE : state == LOAD ? WAIT : state;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      en_q    <= '0;
      rst_q   <= '0;
      div_q   <= '0;
      tgt     <= '0;
      instr_q <= '0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state   <= state_nx;
      en_q    <= b.ctrl_wr ? b.ctrl_data[NSM-1:0] : en_q;
      rst_q   <= b.ctrl_wr ? b.ctrl_data[2*NSM-1:NSM] : '0;
      div_q   <= b.ctrl_wr ? b.ctrl_data[3*NSM-1:2*NSM] : '0;
      tgt     <= accept ? b.exec_sm : tgt;
      instr_q <= accept ? b.exec_instr : instr_q;
      done_q  <= abort || step;
      abort_q <= abort;
    end
  end
  assign b.en          = en_q | (state == WAIT ? tgt_oh : '0);
  assign b.restart     = rst_q;
  assign b.div_restart = div_q;
  assign b.imm         = state == IDLE ? '0 : tgt_oh;
  assign b.imm_instr   = instr_q;
  assign b.exec_busy   = state != IDLE;
  assign b.exec_done   = done_q;
  assign b.exec_abort  = abort_q;
endmodule

// File: tb/tb_pio_sched.sv
// tb_pio_sched: directed and randomized checks of pio_sched against a behavioural model
module tb_pio_sched;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   done_seen = 0;
  pio_sched_if #(.NSM(4)) b();
  pio_sched #(.NSM(4)) dut (.clk(clk), .reset(reset), .b(b));
  always #5 clk = ~clk;
  logic [3:0]  m_en, m_rst, m_div;
  logic [15:0] m_instr;
  logic        m_busy, m_done, m_abort;
  int          m_age, m_tgt;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_en = 0; m_rst = 0; m_div = 0; m_instr = 0;
    m_busy = 0; m_done = 0; m_abort = 0; m_age = 0; m_tgt = 0;
  endtask
  task automatic model_edge();
    logic ab, st;
    m_done = 0; m_abort = 0;
    if (m_busy) begin
      ab = b.ctrl_wr && b.ctrl_data[4 + m_tgt];
      st = m_age >= 1 && b.sm_step[m_tgt];
      if (ab || st) begin
        m_busy = 0; m_done = 1; m_abort = ab;
      end else m_age++;
    end else if (b.exec_req && int'(b.exec_sm) < 4) begin
      m_busy = 1; m_age = 0; m_tgt = int'(b.exec_sm); m_instr = b.exec_instr;
    end
    m_rst = b.ctrl_wr ? b.ctrl_data[7:4] : 4'h0;
    m_div = b.ctrl_wr ? b.ctrl_data[11:8] : 4'h0;
    if (b.ctrl_wr) m_en = b.ctrl_data[3:0];
  endtask
  task automatic check_all(string tag);
    logic [3:0] oh;
    oh = 4'(1 << m_tgt);
    chk({tag, ".en"}, b.en, m_en | ((m_busy && m_age >= 1) ? oh : 4'h0));
    chk({tag, ".restart"}, b.restart, m_rst);
    chk({tag, ".div_restart"}, b.div_restart, m_div);
    chk({tag, ".imm"}, b.imm, m_busy ? oh : 4'h0);
    chk({tag, ".imm_instr"}, b.imm_instr, m_instr);
    chk({tag, ".busy"}, b.exec_busy, m_busy);
    chk({tag, ".done"}, b.exec_done, m_done);
    chk({tag, ".abort"}, b.exec_abort, m_abort);
  endtask
  task automatic tick(string tag);
    @(posedge clk);
    model_edge();
    #1;
    if (b.exec_done) done_seen++;
    check_all(tag);
    b.ctrl_wr = 0; b.exec_req = 0; b.sm_step = 0;
  endtask
  task automatic ctrl(logic [11:0] d);
    b.ctrl_wr = 1; b.ctrl_data = d;
  endtask
  task automatic exec(logic [1:0] sm, logic [15:0] ins);
    b.exec_req = 1; b.exec_sm = sm; b.exec_instr = ins;
  endtask
  initial begin
    b.ctrl_wr = 0; b.ctrl_data = 0; b.exec_req = 0; b.exec_sm = 0;
    b.exec_instr = 0; b.sm_step = 0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk) reset = 1;
    // enable write with restart-all, clearing enables
    ctrl(12'h0F0);
    tick("wr");
    chk("wr_restart_c", b.restart, 4'hF);
    chk("wr_en_c", b.en, 4'h0);
    tick("wr_after");
    chk("wr_restart_clr_c", b.restart, 4'h0);
    // forced exec on a disabled machine
    exec(2'd2, 16'hE001);
    tick("x2_load");
    chk("x2_imm_c", b.imm, 4'b0100);
    chk("x2_instr_c", b.imm_instr, 16'hE001);
    tick("x2_wait");
    chk("x2_en_c", b.en, 4'b0100);
    b.sm_step = 4'b1011;
    tick("x2_other_step");
    b.sm_step = 4'b0100;
    tick("x2_done");
    chk("x2_done_c", b.exec_done, 1'b1);
    chk("x2_en_after_c", b.en, 4'h0);
    tick("x2_idle");
    // exec_req while busy is dropped
    done_seen = 0;
    exec(2'd0, 16'h1234);
    tick("x0_load");
    tick("x0_wait");
    exec(2'd3, 16'hBEEF);
    tick("x0_drop");
    chk("x0_drop_imm_c", b.imm, 4'b0001);
    b.sm_step = 4'b0001;
    tick("x0_done");
    repeat (3) tick("x0_idle");
    chk("x0_one_done_c", done_seen, 1);
    // stalled exec aborted by restart
    exec(2'd1, 16'h2020);
    tick("x1_load");
    repeat (20) tick("x1_stall");
    ctrl(12'h020);
    tick("x1_abort");
    chk("x1_rst_c", b.restart, 4'b0010);
    chk("x1_abort_c", b.exec_abort, 1'b1);
    chk("x1_imm_c", b.imm, 4'h0);
    // abort beats same-cycle step
    exec(2'd1, 16'h3333);
    tick("col_load");
    tick("col_wait");
    ctrl(12'h02F);
    b.sm_step = 4'b0010;
    tick("col");
    chk("col_abort_c", b.exec_abort, 1'b1);
    // same-cycle exec_req and restart of that machine: no abort
    exec(2'd1, 16'h4444);
    ctrl(12'h021);
    tick("same_cyc");
    chk("same_cyc_busy_c", b.exec_busy, 1'b1);
    tick("same_cyc_wait");
    // reset while in WAIT
    #1 reset = 0;
    #1;
    chk("rst_imm_c", b.imm, 4'h0);
    chk("rst_busy_c", b.exec_busy, 1'b0);
    chk("rst_en_c", b.en, 4'h0);
    chk("rst_done_c", b.exec_done, 1'b0);
    model_reset();
    @(negedge clk) reset = 1;
    exec(2'd3, 16'h5555);
    tick("post_rst");
    chk("post_rst_busy_c", b.exec_busy, 1'b1);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) ctrl(12'($urandom));
      if ($urandom_range(0, 3) == 0) exec(2'($urandom), 16'($urandom));
      if ($urandom_range(0, 2) == 0) b.sm_step = 4'($urandom);
      tick("rand");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pio_sched.md
PIO_SCHED -- requirements
Module: pio_sched

Interface
REQ-001 The module SHALL have parameter NSM, default 4, giving the number of state machines scheduled; all per-machine ports are NSM bits wide.
REQ-002 The module SHALL have one clock and an asynchronous active-low reset, with ports listed in REQ-003 to REQ-017.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low; 0 = reset asserted.
REQ-005 ctrl_wr  in  1  single-cycle write strobe for ctrl_data.
REQ-006 ctrl_data  in  3*NSM  fields are [NSM-1:0] enable mask, [2NSM-1:NSM] restart request, [3NSM-1:2NSM] divider-restart request.
REQ-007 exec_req  in  1  request to force-execute one instruction.
REQ-008 exec_sm  in  2  target machine index for exec_req.
REQ-009 exec_instr  in  16  instruction to force-execute.
REQ-010 sm_step  in  NSM  per-machine step strobe: machine executed on this cycle, i.e. en & penable_edge with no stall.
REQ-011 en  out  NSM  per-machine enable.
REQ-012 restart  out  NSM  one-cycle per-machine restart pulse.
REQ-013 div_restart  out  NSM  one-cycle per-machine divider restart pulse.
REQ-014 imm  out  NSM  per-machine forced-instruction select, one-hot or zero.
REQ-015 imm_instr  out  16  forced instruction, broadcast to all machines.
REQ-016 exec_busy  out  1  forced execution in progress.
REQ-017 exec_done / exec_abort  out  1 each  one-cycle completion pulse / abort qualifier.

Function
REQ-018 On ctrl_wr, en SHALL load ctrl_data[NSM-1:0] on that clock edge, and the new value SHALL be visible on the next cycle.
REQ-019 On ctrl_wr, restart and div_restart SHALL pulse high for exactly one cycle, the cycle after the write, on the bits set in their fields; both outputs SHALL be 0 otherwise.
REQ-020 The enable write and the restart requests in one ctrl_wr SHALL take effect in the same cycle.
REQ-021 The exec state machine SHALL have states IDLE, LOAD and WAIT.
REQ-022 In IDLE, exec_req SHALL capture exec_sm and exec_instr into registers, set exec_busy, and go to LOAD.
REQ-023 exec_req arriving while exec_busy=1 SHALL be ignored, with no queueing.
REQ-024 exec_sm >= NSM SHALL be ignored; the block stays in IDLE.
REQ-025 In LOAD, for one cycle, the block SHALL drive imm_instr from the captured instruction and set imm[tgt]=1, then go to WAIT.
REQ-026 In WAIT, imm[tgt] SHALL be held at 1 and en[tgt] SHALL be forced to 1 even if the enable register bit is 0; the other en bits follow the register.
REQ-027 In WAIT, the first sm_step[tgt]=1 SHALL cause: on the next cycle imm=0 and exec_done=1 for one cycle; exec_busy=0 on that same cycle; return to IDLE.
REQ-028 sm_step on non-target machines SHALL be ignored.
REQ-029 A forced instruction that stalls (WAIT, blocking PUSH/PULL, IRQ wait) SHALL keep the block in WAIT indefinitely, with no timeout.
REQ-030 Abort: a ctrl_wr with restart bit tgt set while in LOAD or WAIT SHALL end the exec. The next cycle SHALL have imm=0, exec_done=1, exec_abort=1 and the restart[tgt] pulse together, with return to IDLE.
REQ-031 If the abort write and sm_step[tgt] occur in the same cycle, the abort SHALL take precedence.
REQ-032 exec_req and ctrl_wr in the same cycle SHALL both be accepted.
REQ-033 A same-cycle restart of exec_sm SHALL NOT abort that exec, because the capture has not yet happened.
REQ-034 When IDLE, imm_instr SHALL hold its last value and imm SHALL be 0.
REQ-035 After an exec ends, en[tgt] SHALL revert to the enable register bit.

Reset
REQ-036 While reset=0: en, restart, div_restart and imm SHALL be 0.
REQ-037 While reset=0: imm_instr SHALL be 16'h0000.
REQ-038 While reset=0: exec_busy, exec_done and exec_abort SHALL be 0, and the state SHALL be IDLE.
REQ-039 Reset asserted mid-exec SHALL drop imm and exec_busy asynchronously, with no exec_done pulse.
REQ-040 After reset deasserts, the first ctrl_wr or exec_req SHALL be honoured on the first rising clock edge after deassertion.

Verification
REQ-041 Enable write: ctrl_wr with data 12'h0F0 -> next cycle en=4'h0 and restart=4'hF for one cycle; the cycle after, restart=4'h0.
REQ-042 Forced exec on disabled SM: en=0, exec_req with sm=2 and instr=16'hE001 -> LOAD gives imm=4'b0100; WAIT gives en=4'b0100; sm_step[2] -> next cycle exec_done=1, imm=0, en=0.
REQ-043 Busy drop: exec_req during WAIT with a different sm -> ignored; the original exec completes normally and exactly one exec_done is seen.
REQ-044 Abort: exec on sm=1 stalled in WAIT for 20 cycles, then ctrl_wr with restart bit 1 -> next cycle restart=4'b0010, exec_done=1, exec_abort=1, imm=0.
REQ-045 Collision: ctrl_wr restarting sm=1 in the same cycle as sm_step[1] during WAIT -> abort path taken with exec_abort=1.
REQ-046 Reset mid-exec: reset=0 while in WAIT -> imm, exec_busy and en are 0 immediately; after release, a new exec_req is accepted.
